hsi_rx_frame_checker: RTL and testbench

//  Receive-side framing stage: consumes the deserialised byte stream, hunts
//  for SOF, extracts LEN and payload, and checks the trailing CRC-16/CCITT
//  (poly 0x1021, init 0xFFFF, MSB-first, no reflection/xor-out).

---
 rtl/hsi_rx_frame_checker_if.sv | 29 ++
 rtl/hsi_rx_frame_checker.sv | 174 +++++++++++++++++
 tb/tb_hsi_rx_frame_checker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hsi_rx_frame_checker_if.sv
// hsi_rx_frame_checker_if: receive byte stream in, payload/status out.
// master = byte source/sink side, slave = frame checker.
//  rx_valid/rx_data          byte strobe and received byte
//  pl_valid/pl_data/pl_last  forwarded payload byte, final-byte flag
//  frm_done/frm_ok/frm_err   end-of-frame status pulse
//  busy                      checker is inside a frame
interface hsi_rx_frame_checker_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_last;
    logic       frm_done;
    logic       frm_ok;
    logic [1:0] frm_err;
    logic       busy;

    modport master (
        output rx_valid, rx_data,
        input  pl_valid, pl_data, pl_last,
        input  frm_done, frm_ok, frm_err, busy
    );

    modport slave (
        input  rx_valid, rx_data,
        output pl_valid, pl_data, pl_last,
        output frm_done, frm_ok, frm_err, busy
    );
endinterface

// File: rtl/hsi_rx_frame_checker.sv
// hsi_rx_frame_checker: SOF hunt, LEN/payload extraction, CRC-16/CCITT check.
// Ports: clk, n_rst (async active-low), clr (sync abort), bus (slave side):
//  rx_valid/rx_data in; pl_valid/pl_data/pl_last, frm_done/frm_ok/frm_err,
//  busy out. All outputs except busy are registered; busy decodes state.
module hsi_rx_frame_checker #(
    parameter logic [7:0] SOF_BYTE   = 8'h7E,
    parameter int         MAX_LEN    = 64,
    parameter int         GAP_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clr,
    hsi_rx_frame_checker_if.slave       bus
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAY,
        CRC_H,
        CRC_L
    } state_t;

    state_t        state, state_n;
    logic [15:0]   crc, crc_n;
    logic [7:0]    cnt, cnt_n;
    logic [GW-1:0] gap, gap_n;

    logic          pl_valid, pl_valid_n;
    logic [7:0]    pl_data, pl_data_n;
    logic          pl_last, pl_last_n;
    logic          done, done_n;
    logic          ok, ok_n;
    logic [1:0]    err, err_n;

    logic [15:0]   crc_upd;
    logic          len_legal;
    logic          gap_expired;

    // Byte-wide CCITT step; the loop unrolls into one parallel XOR network.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c_in,
        input logic [7:0]  b
    );
        logic [15:0] c;
        c = c_in ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    assign crc_upd     = crc_step(crc, bus.rx_data);
    assign len_legal   = (bus.rx_data != 8'd0) &&
                         (bus.rx_data <= 8'(MAX_LEN));
    assign gap_expired = (gap == GW'(GAP_CYCLES - 1));

    always_comb begin
        state_n    = state;
        crc_n      = crc;
        cnt_n      = cnt;
        gap_n      = gap;
        pl_valid_n = 1'b0;
        pl_data_n  = 8'h00;
        pl_last_n  = 1'b0;
        done_n     = 1'b0;
        ok_n       = 1'b0;
        err_n      = 2'd0;

        if (clr) begin
            state_n = HUNT;
            crc_n   = 16'hFFFF;
            cnt_n   = 8'd0;
            gap_n   = '0;
        end else if (bus.rx_valid) begin
            // A byte always restarts the idle count, even on the expiry clk.
            gap_n = '0;
            unique case (state)
                HUNT: begin
                    if (bus.rx_data == SOF_BYTE) begin
                        state_n = LEN;
                    end
                end
                LEN: begin
                    if (len_legal) begin
                        cnt_n   = bus.rx_data;
                        crc_n   = 16'hFFFF;
                        state_n = PAY;
                    end else begin
                        done_n  = 1'b1;
                        err_n   = 2'd2;
                        state_n = HUNT;
                    end
                end
                PAY: begin
                    crc_n      = crc_upd;
                    pl_valid_n = 1'b1;
                    pl_data_n  = bus.rx_data;
                    cnt_n      = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        pl_last_n = 1'b1;
                        state_n   = CRC_H;
                    end
                end
                CRC_H: begin
                    crc_n   = crc_upd;
                    state_n = CRC_L;
                end
                CRC_L: begin
                    // Running CRC over payload plus its own CRC leaves zero.
                    crc_n   = 16'hFFFF;
                    done_n  = 1'b1;
                    state_n = HUNT;
                    if (crc_upd == 16'h0000) begin
                        ok_n = 1'b1;
                    end else begin
                        err_n = 2'd1;
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end else if (state != HUNT) begin
            if (gap_expired) begin
                done_n  = 1'b1;
                err_n   = 2'd3;
                state_n = HUNT;
                crc_n   = 16'hFFFF;
                cnt_n   = 8'd0;
                gap_n   = '0;
            end else begin
                gap_n = gap + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= HUNT;
            crc      <= 16'hFFFF;
            cnt      <= 8'd0;
            gap      <= '0;
            pl_valid <= 1'b0;
            pl_data  <= 8'h00;
            pl_last  <= 1'b0;
            done     <= 1'b0;
            ok       <= 1'b0;
            err      <= 2'd0;
        end else begin
            state    <= state_n;
            crc      <= crc_n;
            cnt      <= cnt_n;
            gap      <= gap_n;
            pl_valid <= pl_valid_n;
            pl_data  <= pl_data_n;
            pl_last  <= pl_last_n;
            done     <= done_n;
            ok       <= ok_n;
            err      <= err_n;
        end
    end

    assign bus.pl_valid = pl_valid;
    assign bus.pl_data  = pl_data;
    assign bus.pl_last  = pl_last;
    assign bus.frm_done = done;
    assign bus.frm_ok   = ok;
    assign bus.frm_err  = err;
    assign bus.busy     = (state != HUNT);

endmodule

// File: tb/tb_hsi_rx_frame_checker.sv
// tb_hsi_rx_frame_checker: directed vector table plus hand sequences
// for timeout, expiry-cycle byte, clr and asynchronous reset.
module tb_hsi_rx_frame_checker;

    localparam int GAP = 1024;

    logic clk;
    logic n_rst;
    logic clr;

    hsi_rx_frame_checker_if bus ();

    hsi_rx_frame_checker #(
        .SOF_BYTE   (8'h7E),
        .MAX_LEN    (64),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pl_valid, pl_data, pl_last, frm_done, frm_ok, frm_err, busy}
    logic [14:0] obs;
    assign obs = {bus.pl_valid, bus.pl_data, bus.pl_last,
                  bus.frm_done, bus.frm_ok, bus.frm_err, bus.busy};

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        c;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   passed;
    int   total;

    function automatic logic [14:0] o(
        input logic       pv,
        input logic [7:0] pd,
        input logic       pl,
        input logic       dn,
        input logic       ok,
        input logic [1:0] er,
        input logic       bz
    );
        return {pv, pd, pl, dn, ok, er, bz};
    endfunction

    task automatic check(input string name, input logic [14:0] got,
                         input logic [14:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic v, input logic [7:0] d,
                        input logic c, input logic [14:0] exp);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.c   = c;
        r.exp = exp;
        tbl.push_back(r);
    endtask

    // 7E 09 "123456789" 29 <crc_l>; correct CRC is 0x29B1.
    task automatic push_frame1(input logic [7:0] crc_l);
        logic good;
        good = (crc_l == 8'hB1);
        push(1, 8'h7E, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h09, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        for (int i = 0; i < 9; i++) begin
            push(1, 8'(8'h31 + i), 0,
                 o(1, 8'(8'h31 + i), (i == 8), 0, 0, 2'd0, 1));
        end
        push(1, 8'h29, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, crc_l, 0,
             o(0, 8'h00, 0, 1, good, good ? 2'd0 : 2'd1, 0));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = d;
        clr          = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            check($sformatf("%s[%0d]", tag, i), obs, tbl[i].exp);
        end
        tbl.delete();
    endtask

    task automatic send_partial;
        step(1, 8'h7E, 0);
        step(1, 8'h09, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'(8'h31 + i), 0);
        end
    endtask

    initial begin
        int early;
        passed       = 0;
        total        = 0;
        n_rst        = 1'b0;
        clr          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset", obs, 15'd0);
        n_rst = 1'b1;

        // good frame, then bad CRC
        push_frame1(8'hB1);
        push_frame1(8'hB0);
        // illegal LEN 0 and MAX_LEN+1
        push(1, 8'h7E, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h00, 0, o(0, 8'h00, 0, 1, 0, 2'd2, 0));
        push(1, 8'h7E, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h41, 0, o(0, 8'h00, 0, 1, 0, 2'd2, 0));
        // garbage dropped in HUNT, idle in HUNT
        push(1, 8'h00, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 0));
        push(1, 8'hFF, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 0));
        push(1, 8'h55, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 0));
        push(0, 8'h00, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 0));
        // three back-to-back frames
        push_frame1(8'hB1);
        push_frame1(8'hB1);
        push_frame1(8'hB1);
        // LEN=1 boundary: payload 00, CRC E1F0
        push(1, 8'h7E, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h01, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h00, 0, o(1, 8'h00, 1, 0, 0, 2'd0, 1));
        push(1, 8'hE1, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'hF0, 0, o(0, 8'h00, 0, 1, 1, 2'd0, 0));
        // LEN=MAX_LEN accepted; clr beats a byte mid-PAY, no pulse
        push(1, 8'h7E, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h40, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h31, 0, o(1, 8'h31, 0, 0, 0, 2'd0, 1));
        push(0, 8'h00, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        push(1, 8'h32, 1, o(0, 8'h00, 0, 0, 0, 2'd0, 0));
        push(0, 8'h00, 0, o(0, 8'h00, 0, 0, 0, 2'd0, 0));
        push_frame1(8'hB1);
        run_table("vec");

        // timeout exactly GAP idle clocks after '4'
        send_partial();
        early = 0;
        for (int k = 1; k <= GAP; k++) begin
            step(0, 8'h00, 0);
            if (k < GAP) begin
                if (bus.frm_done !== 1'b0 || bus.busy !== 1'b1) early++;
            end else begin
                check("timeout", obs, o(0, 8'h00, 0, 1, 0, 2'd3, 0));
            end
        end
        total++;
        if (early == 0) passed++;
        else $display("FAIL timeout_early got=%0d early cycles required=0",
                      early);

        // byte on the expiry cycle is taken and restarts the gap count
        send_partial();
        for (int k = 1; k < GAP; k++) step(0, 8'h00, 0);
        step(1, 8'h35, 0);
        check("expiry_byte", obs, o(1, 8'h35, 0, 0, 0, 2'd0, 1));
        step(0, 8'h00, 0);
        check("expiry_after", obs, o(0, 8'h00, 0, 0, 0, 2'd0, 1));
        step(0, 8'h00, 1);
        check("expiry_clr", obs, o(0, 8'h00, 0, 0, 0, 2'd0, 0));

        // asynchronous reset mid-PAY clears outputs without a clock edge
        step(1, 8'h7E, 0);
        step(1, 8'h09, 0);
        step(1, 8'h31, 0);
        check("pre_rst", obs, o(1, 8'h31, 0, 0, 0, 2'd0, 1));
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1 check("async_rst", obs, 15'd0);
        @(negedge clk);
        n_rst = 1'b1;
        push_frame1(8'hB1);
        run_table("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
